// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD card-initialisation sequencer: command
// indices, the identification step and FSM state enums, failure codes,
// fixed command arguments, and the step -> {idx, arg, precnt} decode.
// -----------------------------------------------------------------------------
package sd_pkg;

    // SD command indices used during identification.
    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD2   = 6'd2;
    localparam logic [5:0] CMD3   = 6'd3;
    localparam logic [5:0] CMD7   = 6'd7;
    localparam logic [5:0] CMD8   = 6'd8;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    // Failure causes reported on err_code.
    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_CMD8_CHECK  = 3'd1;
    localparam logic [2:0] ERR_ACMD41_BUSY = 3'd2;
    localparam logic [2:0] ERR_CMD_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_CMD_SYNTAX  = 3'd4;

    // Fixed arguments and idle-clock counts.
    localparam logic [7:0]  CMD8_CHECK     = 8'hAA;
    localparam logic [31:0] CMD8_ARG       = {24'h000001, CMD8_CHECK};
    localparam logic [31:0] DEFAULT_BLKLEN = 32'd512;
    localparam logic [31:0] ACMD41_ARG_V2  = 32'hC010_0000;  // HCS set for v2 cards
    localparam logic [31:0] ACMD41_ARG_V1  = 32'h0010_0000;
    localparam logic [15:0] PRECNT_CMD0    = 16'd80;         // power-up idle clocks
    localparam logic [15:0] PRECNT_DEFAULT = 16'd8;

    typedef enum logic [2:0] {
        STEP_CMD0,
        STEP_CMD8,
        STEP_CMD55,
        STEP_ACMD41,
        STEP_CMD2,
        STEP_CMD3,
        STEP_CMD7,
        STEP_CMD16
    } step_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_EVAL,
        ST_FINISH,
        ST_FAIL
    } state_e;

    // Outcome of evaluating one command response.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_RETRY,
        ACT_FINISH,
        ACT_FAIL
    } eval_act_e;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [15:0] precnt;
    } cmd_req_t;

    // Command fields for a given step. ACMD41 depends on the card version
    // found by CMD8, CMD7 selects the card by the RCA returned from CMD3.
    function automatic cmd_req_t step_decode(input step_e       step,
                                             input logic        card_v2,
                                             input logic [15:0] rca);
        cmd_req_t req;
        req.idx    = CMD0;
        req.arg    = 32'h0;
        req.precnt = PRECNT_DEFAULT;
        case (step)
            STEP_CMD0: begin
                req.idx    = CMD0;
                req.precnt = PRECNT_CMD0;
            end
            STEP_CMD8: begin
                req.idx = CMD8;
                req.arg = CMD8_ARG;
            end
            STEP_CMD55:  req.idx = CMD55;
            STEP_ACMD41: begin
                req.idx = ACMD41;
                req.arg = card_v2 ? ACMD41_ARG_V2 : ACMD41_ARG_V1;
            end
            STEP_CMD2:   req.idx = CMD2;
            STEP_CMD3:   req.idx = CMD3;
            STEP_CMD7: begin
                req.idx = CMD7;
                req.arg = {rca, 16'h0000};
            end
            STEP_CMD16: begin
                req.idx = CMD16;
                req.arg = DEFAULT_BLKLEN;
            end
            default: ;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/sd_init_seq.sv
// -----------------------------------------------------------------------------
// sd_init_seq
// Drives the SD command engine through the power-up identification flow
// (CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7, CMD16), then switches the
// engine to the data-transfer clock divider. Owns the engine request port
// while init_busy is high.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   init_start          one-cycle request, honoured only when idle
//   init_busy           sequence in progress
//   init_done/init_err  one-cycle result pulses, coincide with init_busy falling
//   err_code            failure cause, held until the next init_start
//   card_sdhc, rca      card capacity class and relative address
//   clkdiv              engine clock divider (slow during identification)
//   cmd_start/idx/arg/precnt   command request to the engine
//   cmd_busy/done/timeout/syntaxe/resparg   engine status and response
// -----------------------------------------------------------------------------
module sd_init_seq
    import sd_pkg::*;
#(
    parameter logic [15:0] SLOW_CLKDIV = 16'd99,
    parameter logic [15:0] FAST_CLKDIV = 16'd1,
    parameter logic [15:0] ACMD41_MAX  = 16'd2000,
    parameter logic [1:0]  CMD_RETRY   = 2'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_start,
    output logic        init_busy,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic        card_sdhc,
    output logic [15:0] rca,
    output logic [15:0] clkdiv,
    output logic        cmd_start,
    output logic [15:0] cmd_precnt,
    output logic [5:0]  cmd_idx,
    output logic [31:0] cmd_arg,
    input  logic        cmd_busy,
    input  logic        cmd_done,
    input  logic        cmd_timeout,
    input  logic        cmd_syntaxe,
    input  logic [31:0] cmd_resparg
);

    state_e      state_q;
    step_e       step_q;
    logic [1:0]  retry_q;
    logic [15:0] acmd_cnt_q;
    logic        card_v2_q;
    logic        rsp_timeout_q;
    logic        rsp_syntaxe_q;
    logic [31:0] rsp_arg_q;

    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  err_code_q;
    logic        sdhc_q;
    logic [15:0] rca_q;
    logic [15:0] clkdiv_q;
    logic        start_q;
    logic [15:0] precnt_q;
    logic [5:0]  idx_q;
    logic [31:0] arg_q;

    cmd_req_t    req_d;
    eval_act_e   act_d;
    step_e       next_step_d;
    logic [2:0]  fail_code_d;
    logic [15:0] acmd_cnt_d;
    logic        rsp_err;
    logic        retry_exhausted;
    logic [2:0]  fault_code;
    logic        unused_rsp_bits;

    assign req_d           = step_decode(step_q, card_v2_q, rca_q);
    assign acmd_cnt_d      = (acmd_cnt_q == 16'hFFFF) ? acmd_cnt_q : acmd_cnt_q + 16'd1;
    assign rsp_err         = rsp_timeout_q | rsp_syntaxe_q;
    assign retry_exhausted = (retry_q >= CMD_RETRY);
    assign fault_code      = rsp_timeout_q ? ERR_CMD_TIMEOUT : ERR_CMD_SYNTAX;
    // Response bits [15:8] carry nothing this sequencer needs.
    assign unused_rsp_bits = ^rsp_arg_q[15:8];

    // Decide what the captured response means for the current step.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        act_d       = ACT_ADVANCE;
        next_step_d = step_q;
        fail_code_d = ERR_NONE;
        case (step_q)
            // CMD0 has no response: a timeout is the expected outcome.
            STEP_CMD0: next_step_d = STEP_CMD8;
            STEP_CMD8: begin
                if (rsp_timeout_q) begin
                    next_step_d = STEP_CMD55;  // v1 card ignores CMD8
                end else if (rsp_syntaxe_q) begin
                    act_d       = retry_exhausted ? ACT_FAIL : ACT_RETRY;
                    fail_code_d = fault_code;
                end else if (rsp_arg_q[7:0] != CMD8_CHECK) begin
                    act_d       = ACT_FAIL;
                    fail_code_d = ERR_CMD8_CHECK;
                end else begin
                    next_step_d = STEP_CMD55;
                end
            end
            STEP_ACMD41: begin
                if (rsp_err) begin
                    act_d       = retry_exhausted ? ACT_FAIL : ACT_RETRY;
                    fail_code_d = fault_code;
                end else if (!rsp_arg_q[31]) begin
                    // Card still powering up: loop through CMD55 again.
                    if (acmd_cnt_d >= ACMD41_MAX) begin
                        act_d       = ACT_FAIL;
                        fail_code_d = ERR_ACMD41_BUSY;
                    end else begin
                        next_step_d = STEP_CMD55;
                    end
                end else begin
                    next_step_d = STEP_CMD2;
                end
            end
            default: begin
                if (rsp_err) begin
                    act_d       = retry_exhausted ? ACT_FAIL : ACT_RETRY;
                    fail_code_d = fault_code;
                end else begin
                    case (step_q)
                        STEP_CMD55: next_step_d = STEP_ACMD41;
                        STEP_CMD2:  next_step_d = STEP_CMD3;
                        STEP_CMD3:  next_step_d = STEP_CMD7;
                        STEP_CMD7:  next_step_d = STEP_CMD16;
                        default:    act_d       = ACT_FINISH;  // CMD16
                    endcase
                end
            end
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            step_q        <= STEP_CMD0;
            retry_q       <= 2'd0;
            acmd_cnt_q    <= 16'd0;
            card_v2_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_syntaxe_q <= 1'b0;
            rsp_arg_q     <= 32'h0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= ERR_NONE;
            sdhc_q        <= 1'b0;
            rca_q         <= 16'h0;
            clkdiv_q      <= SLOW_CLKDIV;
            start_q       <= 1'b0;
            precnt_q      <= 16'd0;
            idx_q         <= 6'd0;
            arg_q         <= 32'h0;
        end else begin
            // Pulses last one cycle unless a state below re-asserts them.
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_start) begin
                        busy_q     <= 1'b1;
                        err_code_q <= ERR_NONE;
                        sdhc_q     <= 1'b0;
                        rca_q      <= 16'h0;
                        clkdiv_q   <= SLOW_CLKDIV;
                        step_q     <= STEP_CMD0;
                        retry_q    <= 2'd0;
                        acmd_cnt_q <= 16'd0;
                        card_v2_q  <= 1'b0;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Fields are latched here and held until the next issue.
                    if (!cmd_busy) begin
                        idx_q    <= req_d.idx;
                        arg_q    <= req_d.arg;
                        precnt_q <= req_d.precnt;
                        start_q  <= 1'b1;
                        state_q  <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (cmd_busy) state_q <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (cmd_done) begin
                        rsp_timeout_q <= cmd_timeout;
                        rsp_syntaxe_q <= cmd_syntaxe;
                        rsp_arg_q     <= cmd_resparg;
                        state_q       <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    case (act_d)
                        ACT_ADVANCE: begin
                            step_q  <= next_step_d;
                            retry_q <= 2'd0;
                            state_q <= ST_ISSUE;
                            case (step_q)
                                STEP_CMD8: card_v2_q <= !rsp_timeout_q;
                                STEP_ACMD41: begin
                                    if (rsp_arg_q[31]) sdhc_q <= rsp_arg_q[30];
                                    else acmd_cnt_q <= acmd_cnt_d;
                                end
                                STEP_CMD3: rca_q <= rsp_arg_q[31:16];
                                default: ;
                            endcase
                        end
                        ACT_RETRY: begin
                            retry_q <= retry_q + 2'd1;
                            state_q <= ST_ISSUE;
                        end
                        ACT_FINISH: state_q <= ST_FINISH;
                        ACT_FAIL: begin
                            err_code_q <= fail_code_d;
                            state_q    <= ST_FAIL;
                        end
                        default: state_q <= ST_FAIL;
                    endcase
                end
                ST_FINISH: begin
                    clkdiv_q <= FAST_CLKDIV;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_FAIL: begin
                    clkdiv_q <= SLOW_CLKDIV;
                    err_q    <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_busy  = busy_q;
    assign init_done  = done_q;
    assign init_err   = err_q;
    assign err_code   = err_code_q;
    assign card_sdhc  = sdhc_q;
    assign rca        = rca_q;
    assign clkdiv     = clkdiv_q;
    assign cmd_start  = start_q;
    assign cmd_precnt = precnt_q;
    assign cmd_idx    = idx_q;
    assign cmd_arg    = arg_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// -----------------------------------------------------------------------------
// tb_sd_init_seq
// Self-checking bench for sd_init_seq. A scenario describes how the card
// behaves (CMD8 answer, ACMD41 not-ready count, per-command failures, RCA,
// CCS). A reference model turns the scenario into the expected command list
// and final result; an engine model answers the DUT's commands from the same
// scenario and compares every issued command against the expected list.
// -----------------------------------------------------------------------------
module tb_sd_init_seq;

    localparam logic [15:0] SLOW = 16'd99;
    localparam logic [15:0] FAST = 16'd1;
    localparam int          AMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_start;
    logic        init_busy, init_done, init_err;
    logic [2:0]  err_code;
    logic        card_sdhc;
    logic [15:0] rca, clkdiv, cmd_precnt;
    logic        cmd_start;
    logic [5:0]  cmd_idx;
    logic [31:0] cmd_arg;
    logic        cmd_busy, cmd_done, cmd_timeout, cmd_syntaxe;
    logic [31:0] cmd_resparg;

    always #5 clk = ~clk;

    sd_init_seq #(
        .SLOW_CLKDIV(SLOW),
        .FAST_CLKDIV(FAST),
        .ACMD41_MAX (16'd4),
        .CMD_RETRY  (2'd3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_code   (err_code),
        .card_sdhc  (card_sdhc),
        .rca        (rca),
        .clkdiv     (clkdiv),
        .cmd_start  (cmd_start),
        .cmd_precnt (cmd_precnt),
        .cmd_idx    (cmd_idx),
        .cmd_arg    (cmd_arg),
        .cmd_busy   (cmd_busy),
        .cmd_done   (cmd_done),
        .cmd_timeout(cmd_timeout),
        .cmd_syntaxe(cmd_syntaxe),
        .cmd_resparg(cmd_resparg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scenario description ----------------
    int          sc_cmd8;       // 0 = timeout (v1), 1 = bad check byte, 2 = good (v2)
    int          sc_notready;   // ACMD41 replies with busy before the ready reply
    bit          sc_sdhc;
    logic [15:0] sc_rca;
    int          sc_fail[4];    // failures injected on CMD2, CMD3, CMD7, CMD16
    bit          sc_syn[4];     // failure kind: 1 = syntax error, 0 = timeout
    int          eng_lat_min = 1;
    int          eng_lat_max = 4;

    // ---------------- reference model ----------------
    logic [53:0] exp_q[$];      // {idx, arg, precnt} in issue order
    bit          exp_ok;
    logic [2:0]  exp_code;
    bit          exp_sdhc;
    logic [15:0] exp_rca;

    function automatic void push_cmd(input logic [5:0] idx, input logic [31:0] arg,
                                     input logic [15:0] pre);
        exp_q.push_back({idx, arg, pre});
    endfunction

    // Push one command plus its retries; returns 0 if the card gives up on it.
    function automatic bit push_with_retries(input int slot, input logic [5:0] idx,
                                             input logic [31:0] arg);
        int tries;
        tries = (sc_fail[slot] >= 4) ? 4 : sc_fail[slot] + 1;
        for (int t = 0; t < tries; t++) push_cmd(idx, arg, 16'd8);
        if (sc_fail[slot] >= 4) begin
            exp_code = sc_syn[slot] ? 3'd4 : 3'd3;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void build_model();
        bit v2;
        exp_q.delete();
        exp_ok   = 1'b0;
        exp_code = 3'd0;
        exp_sdhc = 1'b0;
        exp_rca  = 16'h0;
        push_cmd(6'd0, 32'h0, 16'd80);
        push_cmd(6'd8, 32'h0000_01AA, 16'd8);
        if (sc_cmd8 == 1) begin
            exp_code = 3'd1;
            return;
        end
        v2 = (sc_cmd8 == 2);
        for (int i = 0; i <= sc_notready; i++) begin
            push_cmd(6'd55, 32'h0, 16'd8);
            push_cmd(6'd41, v2 ? 32'hC010_0000 : 32'h0010_0000, 16'd8);
            if (i < sc_notready && i + 1 >= AMAX) begin
                exp_code = 3'd2;
                return;
            end
        end
        exp_sdhc = sc_sdhc;
        if (!push_with_retries(0, 6'd2, 32'h0)) return;
        if (!push_with_retries(1, 6'd3, 32'h0)) return;
        exp_rca = sc_rca;
        if (!push_with_retries(2, 6'd7, {sc_rca, 16'h0000})) return;
        if (!push_with_retries(3, 6'd16, 32'd512)) return;
        exp_ok = 1'b1;
    endfunction

    // ---------------- command engine model ----------------
    logic [53:0] eng_req = '0;
    int          eng_cnt = 0;
    bit          eng_first = 1'b0;
    int          eng_n41 = 0;
    int          fail_left[4];
    int          n_cmds = 0;

    function automatic int slot_of(input logic [5:0] idx);
        case (idx)
            6'd2:    return 0;
            6'd3:    return 1;
            6'd7:    return 2;
            default: return 3;
        endcase
    endfunction

    task automatic respond();
        logic [5:0] idx;
        int         s;
        idx         = eng_req[53:48];
        cmd_timeout = 1'b0;
        cmd_syntaxe = 1'b0;
        cmd_resparg = $urandom;
        case (idx)
            6'd0: cmd_timeout = 1'b1;
            6'd8: begin
                if (sc_cmd8 == 0) cmd_timeout = 1'b1;
                else cmd_resparg = (sc_cmd8 == 2) ? 32'h0000_01AA : 32'h0000_01A5;
            end
            6'd55: cmd_resparg = 32'h0000_0120;
            6'd41: begin
                if (eng_n41 < sc_notready)
                    cmd_resparg = {1'b0, 1'($urandom_range(0, 1)), 30'h00FF_8000};
                else
                    cmd_resparg = {1'b1, sc_sdhc, 30'h00FF_8000};
                eng_n41++;
            end
            default: begin
                s = slot_of(idx);
                if (fail_left[s] > 0) begin
                    fail_left[s]--;
                    cmd_timeout = !sc_syn[s];
                    cmd_syntaxe = sc_syn[s];
                end else begin
                    cmd_resparg = (idx == 6'd3) ? {sc_rca, 16'h0500} : 32'h0000_0900;
                end
            end
        endcase
    endtask

    initial begin
        logic [53:0] want;
        cmd_busy    = 1'b0;
        cmd_done    = 1'b0;
        cmd_timeout = 1'b0;
        cmd_syntaxe = 1'b0;
        cmd_resparg = 32'h0;
        forever begin
            @(negedge clk);
            cmd_done = 1'b0;
            if (rst) begin
                eng_cnt  = 0;
                cmd_busy = 1'b0;
            end else if (eng_cnt != 0) begin
                if (eng_first) begin
                    check("cmd_start_single_cycle", cmd_start, 1'b0);
                    eng_first = 1'b0;
                end
                eng_cnt--;
                if (eng_cnt == 0) begin
                    check("cmd_fields_stable", {cmd_idx, cmd_arg, cmd_precnt}, eng_req);
                    respond();
                    cmd_busy = 1'b0;
                    cmd_done = 1'b1;
                end
            end else if (cmd_start) begin
                eng_req = {cmd_idx, cmd_arg, cmd_precnt};
                if (cmd_idx == 6'd0) begin
                    eng_n41   = 0;
                    fail_left = sc_fail;
                end
                n_cmds++;
                want = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
                check($sformatf("cmd#%0d_idx_arg_precnt", n_cmds), eng_req, want);
                cmd_busy  = 1'b1;
                eng_cnt   = $urandom_range(eng_lat_min, eng_lat_max);
                eng_first = 1'b1;
            end
        end
    end

    // ---------------- scenario runner ----------------
    task automatic set_sc(input int c8, input int nr, input bit sdhc, input logic [15:0] r,
                          input int f2, input int f3, input int f7, input int f16, input bit syn);
        sc_cmd8     = c8;
        sc_notready = nr;
        sc_sdhc     = sdhc;
        sc_rca      = r;
        sc_fail[0]  = f2;
        sc_fail[1]  = f3;
        sc_fail[2]  = f7;
        sc_fail[3]  = f16;
        for (int i = 0; i < 4; i++) sc_syn[i] = syn;
    endtask

    task automatic run_scenario(input string name);
        int n0, exp_n;
        bit seen;
        build_model();
        exp_n = exp_q.size();
        n0    = n_cmds;
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        check({name, "_busy_rise"}, init_busy, 1'b1);
        check({name, "_cleared_on_start"}, {err_code, card_sdhc, rca, clkdiv}, {3'd0, 1'b0, 16'h0, SLOW});
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            @(negedge clk);
            init_start = (c == 6);   // must be ignored while busy
            if (init_done || init_err) seen = 1'b1;
        end
        init_start = 1'b0;
        check({name, "_terminated"}, seen, 1'b1);
        if (seen) begin
            check({name, "_done_err"}, {init_done, init_err}, {exp_ok, !exp_ok});
            check({name, "_busy_fall"}, init_busy, 1'b0);
            check({name, "_err_code"}, err_code, exp_code);
            check({name, "_card_sdhc"}, card_sdhc, exp_sdhc);
            check({name, "_rca"}, rca, exp_rca);
            check({name, "_clkdiv"}, clkdiv, exp_ok ? FAST : SLOW);
            check({name, "_cmd_count"}, n_cmds - n0, exp_n);
            @(negedge clk);
            check({name, "_pulse_width"}, {init_done, init_err}, 2'b00);
        end
        exp_q.delete();
    endtask

    task automatic reset_mid_acmd41();
        bit found, err_seen, busy_seen;
        set_sc(2, 5, 1'b1, 16'hBEEF, 0, 0, 0, 0, 1'b0);
        eng_lat_min = 8;
        eng_lat_max = 8;
        build_model();
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            if (cmd_busy && eng_req[53:48] == 6'd41 && !eng_first && eng_cnt >= 3) found = 1'b1;
        end
        check("rst_reached_acmd41_wait", found, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy_start", {init_busy, cmd_start, init_done, init_err}, 4'b0000);
        check("rst_async_clkdiv", clkdiv, SLOW);
        check("rst_async_fields", {err_code, card_sdhc, rca, cmd_idx, cmd_arg, cmd_precnt}, '0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        err_seen  = 1'b0;
        busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            err_seen  |= init_err;
            busy_seen |= init_busy | cmd_start;
        end
        check("rst_no_err_pulse", err_seen, 1'b0);
        check("rst_stays_idle", busy_seen, 1'b0);
        exp_q.delete();
        eng_lat_min = 1;
        eng_lat_max = 4;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        init_start = 1'b0;
        set_sc(2, 0, 1'b0, 16'h0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_flags", {init_busy, init_done, init_err, cmd_start, card_sdhc}, 5'b0);
        check("reset_clkdiv", clkdiv, SLOW);
        check("reset_fields", {err_code, rca, cmd_idx, cmd_arg, cmd_precnt}, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_sc(2, 2, 1'b1, 16'h1234, 0, 0, 0, 0, 1'b0);
        run_scenario("happy_sdhc");
        set_sc(0, 0, 1'b0, 16'h7A01, 0, 0, 0, 0, 1'b0);
        run_scenario("v1_card");
        set_sc(2, 6, 1'b1, 16'h5555, 0, 0, 0, 0, 1'b0);
        run_scenario("acmd41_never_ready");
        set_sc(1, 0, 1'b1, 16'h2222, 0, 0, 0, 0, 1'b0);
        run_scenario("cmd8_bad_pattern");
        set_sc(2, 0, 1'b1, 16'h3333, 0, 4, 0, 0, 1'b0);
        run_scenario("cmd3_timeout_x4");
        set_sc(2, 1, 1'b0, 16'h4444, 0, 2, 0, 0, 1'b0);
        run_scenario("cmd3_timeout_x2");
        set_sc(2, 0, 1'b1, 16'h6666, 0, 0, 0, 4, 1'b1);
        run_scenario("cmd16_syntax_x4");
        set_sc(2, 3, 1'b1, 16'h7777, 3, 0, 3, 0, 1'b1);
        run_scenario("retry_limit_edge");

        reset_mid_acmd41();
        set_sc(2, 0, 1'b1, 16'h1234, 0, 0, 0, 0, 1'b0);
        run_scenario("after_rst");

        for (int n = 0; n < 40; n++) begin
            int r;
            r           = $urandom_range(0, 9);
            sc_cmd8     = (r < 2) ? 0 : (r == 2) ? 1 : 2;
            sc_notready = $urandom_range(0, 5);
            sc_sdhc     = 1'($urandom_range(0, 1));
            sc_rca      = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                sc_fail[i] = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 4);
                sc_syn[i]  = 1'($urandom_range(0, 1));
            end
            run_scenario($sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
